ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of one stored word.
REQ-003 Parameter ADDR_WIDTH, default 2, SHALL set the address width; depth is 2**ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 2, legal 1..15, SHALL set the cycles from read acceptance to ReadReady.
REQ-005 Port clock, input, 1 bit, SHALL be the single rising-edge clock.
REQ-006 Port reset, input, 1 bit, SHALL be the asynchronous active-low reset (0 = in reset).
REQ-007 Port write, input, 1 bit, SHALL be the write strobe, sampled every cycle.
REQ-008 Port WriteAddr, input, ADDR_WIDTH, SHALL be the write address.
REQ-009 Port WriteData, input, DATA_WIDTH, SHALL be the write data.
REQ-010 Port read, input, 1 bit, SHALL be the level read request, held high by the initiator until ReadReady is seen.
REQ-011 Port ReadAddr, input, ADDR_WIDTH, SHALL be the read address, sampled only at read acceptance.
REQ-012 Port ReadData, output, DATA_WIDTH, SHALL carry the read word.
REQ-013 Port ReadReady, output, 1 bit, SHALL indicate that ReadData is valid for the current request.

Function
REQ-014 Storage SHALL be an array of 2**ADDR_WIDTH words, all cleared to 0 by reset.
REQ-015 On every rising edge with write=1, mem[WriteAddr] SHALL take WriteData, in any FSM state.
REQ-016 The read FSM SHALL have states IDLE, WAIT and READY, and SHALL use a 4-bit latency counter.
REQ-017 IDLE with read=1 SHALL capture ReadAddr, load the counter with READ_LATENCY-1 and go to WAIT; if READ_LATENCY=1 it SHALL go directly to READY.
REQ-018 WAIT SHALL decrement the counter each cycle; on the edge where the counter is 0, it SHALL load ReadData from mem[captured address] and go to READY.
REQ-019 ReadReady SHALL be 1 exactly when state=READY (registered), first asserted READ_LATENCY cycles after the acceptance edge.
REQ-020 In READY, ReadData and ReadReady SHALL remain stable while read=1; read=0 SHALL return the FSM to IDLE with ReadReady=0 on the next cycle.
REQ-021 read falling to 0 during WAIT SHALL abort the request to IDLE; ReadReady SHALL NOT assert and ReadData SHALL be unchanged.
REQ-022 A write to the captured address on the same edge that loads ReadData SHALL NOT be seen; the read SHALL return the pre-write value. Writes on earlier edges SHALL be seen.
REQ-023 ReadAddr changes after acceptance SHALL be ignored until the FSM next leaves IDLE.
REQ-024 ReadData SHALL hold its last loaded value in IDLE and WAIT.
REQ-025 After READY returns to IDLE, a new request with read=1 SHALL be accepted no earlier than the cycle after that IDLE entry (one idle cycle minimum).

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, counter=0, ReadReady=0, ReadData=0 and all memory words to 0.
REQ-027 Reset asserted mid-request SHALL discard the request; after reset release, only a fresh read=1 in IDLE SHALL start a read.

Structure
REQ-028 A shared package ram_pkg SHALL hold the FSM state type (IDLE/WAIT/READY) and the default DATA_WIDTH, ADDR_WIDTH and READ_LATENCY constants.
REQ-029 The block SHALL be flat; no sub-module is required.

Verification
REQ-030 Reset, then read=1, ReadAddr=2 -> ReadReady rises 2 cycles after acceptance with ReadData=0x00.
REQ-031 write=1, WriteAddr=1, WriteData=0xA5 for 1 cycle, then read of address 1 -> ReadData=0xA5 with ReadReady; read=0 -> ReadReady=0 on the next cycle.
REQ-032 Same-edge collision: mem[3]=0x11, write 0x22 to address 3 on the ReadData load edge -> ReadData=0x11; a subsequent read returns 0x22.
REQ-033 read dropped during WAIT -> ReadReady never asserts and ReadData keeps its prior value; the next read completes normally.
REQ-034 reset=0 while in WAIT after writing 0x5A to address 0 -> ReadReady=0 and ReadData=0 immediately; a post-reset read of address 0 returns 0x00.
REQ-035 READ_LATENCY=1 and READ_LATENCY=15 builds -> ReadReady asserts exactly 1 and 15 cycles after acceptance, respectively.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the ram_responder block: default geometry, read
// latency, and the read FSM state encoding.
package ram_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_ADDR_WIDTH   = 2;
  localparam int DEFAULT_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ram_responder.sv
// Small register-file RAM with a posted write port and a level-request read
// port that answers after a fixed latency.
//
// Read handshake: the initiator raises read and holds it until ReadReady is seen.
// ReadReady stays high, with ReadData stable, for as long as read stays high.
// Dropping read ends the transaction in READY, or aborts it in WAIT.
module ram_responder
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ReadReady,
  output logic [1:0]            dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  rd_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (write) begin
      mem_q[WriteAddr] <= WriteData;
    end
  end

  // The counter counts down to 0 and reaches it on the ReadData load edge.
  // ReadReady therefore rises on the READ_LATENCY-th edge, counting the
  // acceptance edge as the first. The load samples mem_q, so a write on
  // that same edge is not seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (read) begin
          raddr_d = ReadAddr;
          if (READ_LATENCY == 1) begin
            rdata_d = mem_q[ReadAddr];
            cnt_d   = '0;
            state_d = READY;
          end else begin
            cnt_d   = LAT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!read) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          rdata_d = mem_q[raddr_q];
          cnt_d   = '0;
          state_d = READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: begin
        if (!read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
    end
  end

  assign ReadData    = rdata_q;
  assign ReadReady   = (state_q == READY);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: default build (latency 2) plus latency-1
// and latency-15 builds that share the write port and the read address.
module tb_ram_responder;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clock;
  logic          reset;
  logic          write;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;
  logic          read, read1, read15;
  logic [AW-1:0] ReadAddr;
  logic [DW-1:0] rdata, rdata1, rdata15;
  logic          rdy, rdy1, rdy15;
  logic [1:0]    st, st1, st15;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  ram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut (
    .clock(clock), .reset(reset), .write(write), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .read(read), .ReadAddr(ReadAddr),
    .ReadData(rdata), .ReadReady(rdy), .dbg_state_o(st)
  );

  ram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset(reset), .write(write), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .read(read1), .ReadAddr(ReadAddr),
    .ReadData(rdata1), .ReadReady(rdy1), .dbg_state_o(st1)
  );

  ram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(15)) u_dut_l15 (
    .clock(clock), .reset(reset), .write(write), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .read(read15), .ReadAddr(ReadAddr),
    .ReadData(rdata15), .ReadReady(rdy15), .dbg_state_o(st15)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares read data against the oldest expected word in the scoreboard.
  task automatic check_data(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  // driver tasks: inputs change only while the clock is low
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = 1'b1; WriteAddr = a; WriteData = d;
    step();
    write = 1'b0;
  endtask

  // Counts edges from the acceptance edge (edge 1) until ReadReady is seen.
  task automatic wait_ready(input int which, output int n);
    logic r;
    n = 0;
    do begin
      step();
      n++;
      r = (which == 1) ? rdy1 : (which == 15) ? rdy15 : rdy;
    end while (!r && n < 40);
  endtask

  int n;

  initial begin
    reset = 1'b0; write = 1'b0; WriteAddr = '0; WriteData = '0;
    read = 1'b0; read1 = 1'b0; read15 = 1'b0; ReadAddr = '0;
    repeat (3) step();
    check("reset_ready", 32'(rdy), 32'd0);
    check("reset_data", 32'(rdata), 32'd0);
    check("reset_state", 32'(st), 32'd0);
    reset = 1'b1;
    step();

    // read of an untouched word after reset
    read = 1'b1; ReadAddr = 2'd2;
    exp_q.push_back(8'h00);
    wait_ready(2, n);
    check("lat2_first_read", 32'(n), 32'd2);
    check_data("first_read_data", rdata);
    read = 1'b0;
    step();
    check("first_read_release", 32'(rdy), 32'd0);
    step();

    // write then read back, with ReadAddr changed after acceptance
    do_write(2'd1, 8'hA5);
    read = 1'b1; ReadAddr = 2'd1;
    step();
    check("a5_wait_not_ready", 32'(rdy), 32'd0);
    check("a5_wait_state", 32'(st), 32'd1);
    ReadAddr = 2'd0;
    step();
    exp_q.push_back(8'hA5);
    check("a5_ready", 32'(rdy), 32'd1);
    check_data("a5_data", rdata);
    step();
    exp_q.push_back(8'hA5);
    check("a5_hold_ready", 32'(rdy), 32'd1);
    check_data("a5_hold_data", rdata);
    read = 1'b0;
    step();
    exp_q.push_back(8'hA5);
    check("a5_release", 32'(rdy), 32'd0);
    check_data("a5_idle_data", rdata);
    step();

    // write on the ReadData load edge is not seen
    do_write(2'd3, 8'h11);
    step();
    read = 1'b1; ReadAddr = 2'd3;
    step();
    write = 1'b1; WriteAddr = 2'd3; WriteData = 8'h22;
    step();
    write = 1'b0;
    exp_q.push_back(8'h11);
    check("collide_ready", 32'(rdy), 32'd1);
    check_data("collide_data", rdata);
    read = 1'b0;
    step();
    step();
    read = 1'b1; ReadAddr = 2'd3;
    wait_ready(2, n);
    exp_q.push_back(8'h22);
    check("collide_reread_lat", 32'(n), 32'd2);
    check_data("collide_reread_data", rdata);
    read = 1'b0;
    step();
    step();

    // abort during WAIT
    read = 1'b1; ReadAddr = 2'd1;
    step();
    read = 1'b0;
    step();
    exp_q.push_back(8'h22);
    check("abort_ready", 32'(rdy), 32'd0);
    check_data("abort_data", rdata);
    step();
    exp_q.push_back(8'h22);
    check("abort_ready_later", 32'(rdy), 32'd0);
    check("abort_state", 32'(st), 32'd0);
    check_data("abort_data_later", rdata);
    read = 1'b1; ReadAddr = 2'd1;
    wait_ready(2, n);
    exp_q.push_back(8'hA5);
    check("post_abort_lat", 32'(n), 32'd2);
    check_data("post_abort_data", rdata);
    read = 1'b0;
    step();
    step();

    // asynchronous reset while in WAIT
    do_write(2'd0, 8'h5A);
    read = 1'b1; ReadAddr = 2'd0;
    step();
    check("pre_reset_state", 32'(st), 32'd1);
    reset = 1'b0;
    #1;
    exp_q.push_back(8'h00);
    check("async_reset_ready", 32'(rdy), 32'd0);
    check("async_reset_state", 32'(st), 32'd0);
    check_data("async_reset_data", rdata);
    read = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("post_reset_idle", 32'(rdy), 32'd0);
    read = 1'b1; ReadAddr = 2'd0;
    wait_ready(2, n);
    exp_q.push_back(8'h00);
    check("post_reset_lat", 32'(n), 32'd2);
    check_data("post_reset_data", rdata);
    read = 1'b0;
    step();

    // latency 1 and latency 15 builds
    do_write(2'd2, 8'h3C);
    read1 = 1'b1; ReadAddr = 2'd2;
    wait_ready(1, n);
    exp_q.push_back(8'h3C);
    check("lat1_cycles", 32'(n), 32'd1);
    check_data("lat1_data", rdata1);
    read1 = 1'b0;
    step();
    check("lat1_release", 32'(rdy1), 32'd0);
    read15 = 1'b1; ReadAddr = 2'd2;
    wait_ready(15, n);
    exp_q.push_back(8'h3C);
    check("lat15_cycles", 32'(n), 32'd15);
    check_data("lat15_data", rdata15);
    read15 = 1'b0;
    step();
    check("lat15_release", 32'(rdy15), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
